tf328_bus_master: RTL

TF328_BUS_MASTER -- requirements
Module: tf328_bus_master

---
 rtl/tf328_bus_master.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/tf328_bus_master.sv
// 68020-style asynchronous bus master: one request becomes one or more bus
// cycles, with dynamic bus sizing from DSACK, bus-error and timeout aborts.
module tf328_bus_master #(
    parameter int TIMEOUT = 64
) (
    input  logic        CLKCPU,
    input  logic        RESET,
    input  logic        req,
    input  logic        req_we,
    input  logic [23:0] req_addr,
    input  logic [1:0]  req_siz,
    input  logic [31:0] req_wdata,
    output logic        busy,
    output logic        ack,
    output logic        err,
    output logic [31:0] rdata,
    output logic [23:0] A,
    output logic [1:0]  SIZ,
    output logic        RW20,
    output logic        AS20,
    output logic        DS20,
    input  logic [31:0] D_IN,
    output logic [31:0] D_OUT,
    output logic        D_OE,
    input  logic [1:0]  DSACK,
    input  logic        BERR
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_STROBE,
        S_WAIT,
        S_TERM,
        S_DONE
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      state_q;
    logic        busy_q, ack_q, err_q;
    logic [31:0] rdata_q;
    logic [23:0] a_q;
    logic [1:0]  siz_q;
    logic        rw_q, as_q, ds_q;
    logic [31:0] dout_q;
    logic        doe_q;

    logic        we_q;
    logic [23:0] addr_q;
    logic [2:0]  rem_q;
    logic [31:0] wsh_q;
    logic [31:0] acc_q;
    logic        fail_q;
    logic [7:0]  tmo_q;

    logic [2:0]  req_bytes_d;
    logic        req_bad_d;
    logic [31:0] req_wsh_d;
    logic [2:0]  port_bytes_d;
    logic [2:0]  chunk_d;
    logic [1:0]  offs_d;
    logic [31:0] lane_d;
    logic [31:0] rbytes_d;
    logic [31:0] acc_d;
    logic [31:0] wsh_d;

    // Remaining write bytes sit left-justified in w; narrow remainders are
    // replicated so any port width finds them on its own lanes.
    function automatic logic [31:0] fmt_dout(input logic [31:0] w, input logic [2:0] n);
        case (n)
            3'd4:    return w;
            3'd3:    return {w[31:8], 8'h00};
            3'd2:    return {2{w[31:16]}};
            3'd1:    return {4{w[31:24]}};
            default: return 32'h0;
        endcase
    endfunction

    always_comb begin
        req_bytes_d = 3'd0;
        req_wsh_d   = req_wdata;
        case (req_siz)
            2'b01: begin req_bytes_d = 3'd1; req_wsh_d = {req_wdata[7:0], 24'h0};  end
            2'b10: begin req_bytes_d = 3'd2; req_wsh_d = {req_wdata[15:0], 16'h0}; end
            2'b00: begin req_bytes_d = 3'd4; req_wsh_d = req_wdata;                end
            default: begin req_bytes_d = 3'd0; req_wsh_d = req_wdata;              end
        endcase
        req_bad_d = (req_siz == 2'b11)
                  || (req_siz == 2'b10 && req_addr[0])
                  || (req_siz == 2'b00 && req_addr[1:0] != 2'b00);

        port_bytes_d = 3'd0;
        offs_d       = 2'b00;
        case (DSACK)
            2'b00: begin port_bytes_d = 3'd4; offs_d = addr_q[1:0];         end
            2'b01: begin port_bytes_d = 3'd2; offs_d = {1'b0, addr_q[0]};   end
            2'b10: begin port_bytes_d = 3'd1; offs_d = 2'b00;               end
            default: begin port_bytes_d = 3'd0; offs_d = 2'b00;             end
        endcase
        chunk_d = (port_bytes_d < rem_q) ? port_bytes_d : rem_q;

        // Shift the addressed byte lane up to D[31:24], then keep chunk_d bytes.
        lane_d = D_IN << {offs_d, 3'b000};
        case (chunk_d)
            3'd1:    rbytes_d = {24'h0, lane_d[31:24]};
            3'd2:    rbytes_d = {16'h0, lane_d[31:16]};
            3'd3:    rbytes_d = {8'h0, lane_d[31:8]};
            3'd4:    rbytes_d = lane_d;
            default: rbytes_d = 32'h0;
        endcase

        case (chunk_d)
            3'd1:    begin acc_d = {acc_q[23:0], rbytes_d[7:0]};  wsh_d = {wsh_q[23:0], 8'h0};  end
            3'd2:    begin acc_d = {acc_q[15:0], rbytes_d[15:0]}; wsh_d = {wsh_q[15:0], 16'h0}; end
            3'd3:    begin acc_d = {acc_q[7:0], rbytes_d[23:0]};  wsh_d = {wsh_q[7:0], 24'h0};  end
            3'd4:    begin acc_d = rbytes_d;                      wsh_d = 32'h0;                end
            default: begin acc_d = acc_q;                         wsh_d = wsh_q;                end
        endcase
    end

    always_ff @(posedge CLKCPU) begin
        if (RESET) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
            a_q     <= 24'h0;
            siz_q   <= 2'b00;
            rw_q    <= 1'b1;
            as_q    <= 1'b1;
            ds_q    <= 1'b1;
            dout_q  <= 32'h0;
            doe_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 24'h0;
            rem_q   <= 3'd0;
            wsh_q   <= 32'h0;
            acc_q   <= 32'h0;
            fail_q  <= 1'b0;
            tmo_q   <= 8'h0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        busy_q <= 1'b1;
                        we_q   <= req_we;
                        fail_q <= 1'b0;
                        acc_q  <= 32'h0;
                        if (req_bad_d) begin
                            state_q <= S_DONE;
                            err_q   <= 1'b1;
                            rdata_q <= 32'h0;
                        end else begin
                            state_q <= S_ADDR;
                            addr_q  <= req_addr;
                            rem_q   <= req_bytes_d;
                            wsh_q   <= req_wsh_d;
                            a_q     <= req_addr;
                            siz_q   <= req_bytes_d[1:0];
                            rw_q    <= ~req_we;
                            dout_q  <= fmt_dout(req_wsh_d, req_bytes_d);
                            as_q    <= 1'b1;
                            ds_q    <= 1'b1;
                        end
                    end
                end
                S_ADDR: begin
                    state_q <= S_STROBE;
                    as_q    <= 1'b0;
                    ds_q    <= we_q;
                    doe_q   <= we_q;
                end
                S_STROBE: begin
                    state_q <= S_WAIT;
                    ds_q    <= 1'b0;
                    tmo_q   <= 8'h0;
                end
                S_WAIT: begin
                    // Bus error wins over a simultaneous DSACK.
                    if (!BERR) begin
                        fail_q  <= 1'b1;
                        state_q <= S_TERM;
                        as_q    <= 1'b1;
                        ds_q    <= 1'b1;
                    end else if (DSACK != 2'b11) begin
                        if (!we_q) acc_q <= acc_d;
                        addr_q  <= addr_q + 24'(chunk_d);
                        rem_q   <= rem_q - chunk_d;
                        wsh_q   <= wsh_d;
                        state_q <= S_TERM;
                        as_q    <= 1'b1;
                        ds_q    <= 1'b1;
                    end else if (tmo_q == TMO_LAST) begin
                        fail_q  <= 1'b1;
                        state_q <= S_TERM;
                        as_q    <= 1'b1;
                        ds_q    <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + 8'd1;
                    end
                end
                S_TERM: begin
                    doe_q <= 1'b0;
                    if (fail_q || rem_q == 3'd0) begin
                        state_q <= S_DONE;
                        rw_q    <= 1'b1;
                        ack_q   <= ~fail_q;
                        err_q   <= fail_q;
                        rdata_q <= fail_q ? 32'h0 : acc_q;
                    end else begin
                        state_q <= S_ADDR;
                        a_q     <= addr_q;
                        siz_q   <= rem_q[1:0];
                        rw_q    <= ~we_q;
                        dout_q  <= fmt_dout(wsh_q, rem_q);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy  = busy_q;
    assign ack   = ack_q;
    assign err   = err_q;
    assign rdata = rdata_q;
    assign A     = a_q;
    assign SIZ   = siz_q;
    assign RW20  = rw_q;
    assign AS20  = as_q;
    assign DS20  = ds_q;
    assign D_OUT = dout_q;
    assign D_OE  = doe_q;

endmodule
